// File: rtl/fwrisc_loader_pkg.sv
// Shared types and constants for the framed program loader.
package fwrisc_loader_pkg;

  typedef enum logic [2:0] {
    StSync,
    StLenH,
    StLenL,
    StData,
    StCsum,
    StDone
  } loader_state_e;

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrLen     = 2'd1;
  localparam logic [1:0] ErrCsum    = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  localparam logic [7:0] SyncByteDefault = 8'hA5;

endpackage

// File: rtl/fwrisc_prog_loader_if.sv
// UART receive handshake and ITCM write port seen by the program loader.
interface fwrisc_prog_loader_if #(
  parameter int unsigned AW = 12
);
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          rx_en_o;
  logic          full_o;
  logic          rom_we_o;
  logic [AW-1:0] rom_addr_o;
  logic [31:0]   rom_wdata_o;

  modport master (
    input  rx_data_i,
    input  rx_valid_i,
    output rx_en_o,
    output full_o,
    output rom_we_o,
    output rom_addr_o,
    output rom_wdata_o
  );

  modport slave (
    output rx_data_i,
    output rx_valid_i,
    input  rx_en_o,
    input  full_o,
    input  rom_we_o,
    input  rom_addr_o,
    input  rom_wdata_o
  );
endinterface

// File: rtl/fwrisc_loader_word_asm.sv
// Big-endian byte-to-word assembler; pulses word_valid_o the cycle after the 4th byte.
module fwrisc_loader_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d;
  logic        valid_q, valid_d;

  // Next accepted byte completes the current word.
  assign last_byte_o  = (cnt_q == 2'd3);
  assign word_valid_o = valid_q;
  assign word_o       = sr_q;

  always_comb begin
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (valid_i) begin
      sr_d    = {sr_q[23:0], data_i};
      cnt_d   = cnt_q + 2'd1;
      valid_d = (cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      sr_q    <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/fwrisc_prog_loader.sv
// Framed ITCM loader: sync, 16-bit word count, payload, mod-256 checksum.
module fwrisc_prog_loader
  import fwrisc_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned AW        = $clog2(DEPTH),
  parameter logic [7:0]  SYNC_BYTE = SyncByteDefault,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fwrisc_prog_loader_if.master bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           err_o
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  loader_state_e state_q, state_d;
  logic [1:0]    err_q, err_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [AW:0]   word_cnt_q, word_cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;

  logic        strobe, active, timeout;
  logic        asm_valid, asm_clear, asm_last;
  logic [7:0]  rx;

  assign rx      = bus.rx_data_i;
  assign strobe  = bus.rx_valid_i;
  assign active  = (state_q != StSync) && (state_q != StDone);
  // An arriving byte always beats the timeout in the same cycle.
  assign timeout = active && !strobe && (idle_q == TW'(TIMEOUT - 1));

  fwrisc_loader_word_asm u_word_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (asm_clear),
    .valid_i      (asm_valid),
    .data_i       (rx),
    .last_byte_o  (asm_last),
    .word_valid_o (bus.rom_we_o),
    .word_o       (bus.rom_wdata_o)
  );

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    len_d      = len_q;
    csum_d     = csum_q;
    word_cnt_d = word_cnt_q;
    rom_addr_d = rom_addr_q;
    idle_d     = '0;
    asm_valid  = 1'b0;
    asm_clear  = 1'b0;

    if (active && !strobe) idle_d = idle_q + TW'(1);

    if (timeout) begin
      err_d      = ErrTimeout;
      word_cnt_d = '0;
      asm_clear  = 1'b1;
      idle_d     = '0;
      state_d    = StSync;
    end else if (strobe) begin
      unique case (state_q)
        StSync: begin
          if (rx == SYNC_BYTE) begin
            err_d      = ErrNone;
            csum_d     = 8'd0;
            word_cnt_d = '0;
            asm_clear  = 1'b1;
            state_d    = StLenH;
          end
        end
        StLenH: begin
          len_d   = {8'h00, rx};
          csum_d  = csum_q + rx;
          state_d = StLenL;
        end
        StLenL: begin
          len_d  = {len_q[7:0], rx};
          csum_d = csum_q + rx;
          if ((len_d == 16'd0) || (32'(len_d) > DEPTH)) begin
            err_d   = ErrLen;
            state_d = StSync;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          csum_d    = csum_q + rx;
          asm_valid = 1'b1;
          if (asm_last) begin
            rom_addr_d = word_cnt_q[AW-1:0];
            word_cnt_d = word_cnt_q + {{AW{1'b0}}, 1'b1};
            if (32'(word_cnt_q) + 32'd1 == 32'(len_q)) state_d = StCsum;
          end
        end
        StCsum: begin
          if (rx == csum_q) begin
            state_d = StDone;
          end else begin
            err_d   = ErrCsum;
            state_d = StSync;
          end
        end
        StDone: ;
        default: state_d = StSync;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StSync;
      err_q      <= ErrNone;
      len_q      <= 16'd0;
      csum_q     <= 8'd0;
      word_cnt_q <= '0;
      idle_q     <= '0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      word_cnt_q <= word_cnt_d;
      idle_q     <= idle_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign bus.rom_addr_o = rom_addr_q;
  assign bus.rx_en_o    = (state_q != StDone);
  assign bus.full_o     = (state_q == StDone);
  assign busy_o         = active;
  assign done_o         = (state_q == StDone);
  assign err_o          = err_q;
endmodule

// File: tb/tb_fwrisc_prog_loader.sv
// Directed bench for the framed program loader.
module tb_fwrisc_prog_loader;
  localparam int unsigned TO = 40;

  logic clk;
  logic rst_n;
  logic busy, done;
  logic [1:0] err;

  fwrisc_prog_loader_if #(.AW(12)) bus ();

  fwrisc_prog_loader #(
    .DEPTH     (4096),
    .AW        (12),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.master),
    .busy_o (busy),
    .done_o (done),
    .err_o  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  int unsigned wr_cnt = 0;
  logic [11:0] wr_addr [16];
  logic [31:0] wr_data [16];

  always @(negedge clk) begin
    if (rst_n && bus.rom_we_o) begin
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] = bus.rom_addr_o;
        wr_data[wr_cnt] = bus.rom_wdata_o;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  logic [7:0] tx [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Back-to-back strobes; returns 1 time unit after the edge that took the last byte.
  task automatic send_tx();
    @(posedge clk);
    #1;
    foreach (tx[i]) begin
      bus.rx_data_i  = tx[i];
      bus.rx_valid_i = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rx_en"}, 32'(bus.rx_en_o), 32'd1);
    check({tag, " full"}, 32'(bus.full_o), 32'd0);
    check({tag, " we"}, 32'(bus.rom_we_o), 32'd0);
    check({tag, " addr"}, 32'(bus.rom_addr_o), 32'd0);
    check({tag, " wdata"}, bus.rom_wdata_o, 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Noise, then length DEPTH+1
    tx = {8'h00, 8'hFF, 8'h5A};
    send_tx();
    check("noise busy", 32'(busy), 32'd0);
    check("noise err", 32'(err), 32'd0);
    tx = {8'hA5};
    send_tx();
    check("sync busy", 32'(busy), 32'd1);
    wr_cnt = 0;
    tx = {8'h10, 8'h01};
    send_tx();
    repeat (2) @(posedge clk);
    #1;
    check("len1001 err", 32'(err), 32'd1);
    check("len1001 busy", 32'(busy), 32'd0);
    check("len1001 writes", wr_cnt, 32'd0);

    tx = {8'hA5, 8'h00, 8'h00};
    send_tx();
    check("len0 err", 32'(err), 32'd1);
    check("len0 busy", 32'(busy), 32'd0);

    // Bad checksum: words still land in ROM
    wr_cnt = 0;
    tx = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
          8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h3B};
    send_tx();
    check("badcs writes", wr_cnt, 32'd2);
    check("badcs addr0", 32'(wr_addr[0]), 32'd0);
    check("badcs data0", wr_data[0], 32'h12345678);
    check("badcs addr1", 32'(wr_addr[1]), 32'd1);
    check("badcs data1", wr_data[1], 32'h9ABCDEF0);
    check("badcs err", 32'(err), 32'd2);
    check("badcs done", 32'(done), 32'd0);
    check("badcs busy", 32'(busy), 32'd0);

    // Timeout in DATA
    wr_cnt = 0;
    tx = {8'hA5, 8'h00, 8'h01, 8'h12};
    send_tx();
    repeat (TO - 2) @(posedge clk);
    #1;
    check("to early err", 32'(err), 32'd0);
    check("to early busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("to err", 32'(err), 32'd3);
    check("to busy", 32'(busy), 32'd0);
    check("to writes", wr_cnt, 32'd0);

    // Good frame
    wr_cnt = 0;
    tx = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
          8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h3A};
    send_tx();
    check("good writes", wr_cnt, 32'd2);
    check("good addr0", 32'(wr_addr[0]), 32'd0);
    check("good data0", wr_data[0], 32'h12345678);
    check("good addr1", 32'(wr_addr[1]), 32'd1);
    check("good data1", wr_data[1], 32'h9ABCDEF0);
    check("good done", 32'(done), 32'd1);
    check("good rx_en", 32'(bus.rx_en_o), 32'd0);
    check("good full", 32'(bus.full_o), 32'd1);
    check("good err", 32'(err), 32'd0);
    check("good busy", 32'(busy), 32'd0);

    // Post-DONE traffic is ignored
    wr_cnt = 0;
    tx = {8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
    send_tx();
    repeat (3) @(posedge clk);
    #1;
    check("postdone writes", wr_cnt, 32'd0);
    check("postdone done", 32'(done), 32'd1);
    check("postdone busy", 32'(busy), 32'd0);

    // Reset in the middle of DATA
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_cnt = 0;
    tx = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    send_tx();
    check("mid busy", 32'(busy), 32'd1);
    check("mid writes", wr_cnt, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    wr_cnt = 0;
    tx = {8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h39};
    send_tx();
    check("fresh writes", wr_cnt, 32'd1);
    check("fresh addr0", 32'(wr_addr[0]), 32'd0);
    check("fresh data0", wr_data[0], 32'hDEADBEEF);
    check("fresh done", 32'(done), 32'd1);
    check("fresh err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end
endmodule
